// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement mode enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

`ifdef SEQ_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] dvd, dvd_nxt;
    logic [WIDTH-1:0] dsr, dsr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
    logic [WIDTH-1:0] mag_dividend, mag_divisor;

    // Shift-and-subtract step: {acc,dvd} << 1, trial subtract at WIDTH+1 bits
    logic [WIDTH:0]   shifted, trial;
    logic             borrow;
    logic [WIDTH-1:0] acc_iter, dvd_iter;

    assign shifted  = {acc, dvd[WIDTH-1]};
    assign trial    = shifted - {1'b0, dsr};
    assign borrow   = trial[WIDTH];
    assign acc_iter = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dvd_iter = {dvd[WIDTH-2:0], ~borrow};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg, q_neg_nxt, r_neg, r_neg_nxt;

    assign mag_dividend = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    assign mag_dividend = dividend;
    assign mag_divisor  = divisor;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            dvd         <= dvd_nxt;
            dsr         <= dsr_nxt;
            cnt         <= cnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            div_by_zero <= dbz_nxt;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg       <= q_neg_nxt;
            r_neg       <= r_neg_nxt;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        dvd_nxt       = dvd;
        dsr_nxt       = dsr;
        cnt_nxt       = cnt;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;
        dbz_nxt       = div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg_nxt     = q_neg;
        r_neg_nxt     = r_neg;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_nxt     = DONE;
                        quotient_nxt  = '1;
                        remainder_nxt = dividend;
                        dbz_nxt       = 1'b1;
                    end else begin
                        state_nxt = CALC;
                        acc_nxt   = '0;
                        dvd_nxt   = mag_dividend;
                        dsr_nxt   = mag_divisor;
                        cnt_nxt   = CNT_W'(WIDTH - 1);
                        busy_nxt  = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        q_neg_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_nxt = dividend[WIDTH-1];
`endif
                    end
                end
            end
            CALC: begin
                acc_nxt = acc_iter;
                dvd_nxt = dvd_iter;
                cnt_nxt = cnt - 1'b1;
                if (cnt == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_nxt     = FIX;
`else
                    state_nxt     = DONE;
                    busy_nxt      = 1'b0;
                    quotient_nxt  = dvd_iter;
                    remainder_nxt = acc_iter;
                    dbz_nxt       = 1'b0;
`endif
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            // Reapply signs to the magnitude results; truncation toward zero
            FIX: begin
                state_nxt     = DONE;
                busy_nxt      = 1'b0;
                quotient_nxt  = q_neg ? -dvd : dvd;
                remainder_nxt = r_neg ? -acc : acc;
                dbz_nxt       = 1'b0;
            end
`endif
            DONE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT  = W + 2;
    localparam int BUSY = W + 1;
`else
    localparam int LAT  = W + 1;
    localparam int BUSY = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int sa, sb;
        z = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        logic [W-1:0] eq, er;
        logic         ez;
        int           edges, busy_cnt;
        model(a, b, eq, er, ez);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            busy_cnt += int'(busy);
            if (inject && edges == 3) begin
                start    = 1'b1;
                dividend = W'(50);
                divisor  = W'(5);
            end
            if (inject && edges == 4) start = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", edges, (b == 0) ? 1 : LAT);
        check("busy_cycles", busy_cnt, (b == 0) ? 0 : BUSY);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("held_quotient", quotient, eq);
        check("held_remainder", remainder, er);
    endtask

    initial begin
        int t;
        logic [W-1:0] ra, rb;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(W'(100), W'(7), 1'b0);
        run_op(W'(3), W'(10), 1'b0);
        run_op(W'(255), W'(1), 1'b0);
        run_op(W'(5), W'(0), 1'b0);
        run_op(W'(200), W'(9), 1'b1);
        run_op(W'(8'hF9), W'(2), 1'b0);
        run_op(W'(8'h80), W'(8'hFF), 1'b0);

        // Reset during the fourth CALC cycle abandons the operation
        @(negedge clk);
        dividend = W'(100);
        divisor  = W'(7);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        t = 0;
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            t += int'(done);
        end
        check("midrst_no_done", t, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(W'(100), W'(7), 1'b0);

        // Start held high: a new operation follows every done
        @(negedge clk);
        dividend = W'(100);
        divisor  = W'(7);
        start    = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!done && t < 40);
        check("hold_first_done", done, 1);
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!done && t < 40);
        start = 1'b0;
        check("hold_gap", t, LAT + 1);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
